// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two requesters, each with an
// operation channel (req_*) and a one-deep result channel (rsp_*).
// Per-requester fields are packed side by side; requester i owns
// slice [i*XLEN +: XLEN] of the operand/result vectors and [i*3 +: 3] of req_op.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [5:0]        req_op;
  logic [1:0]        req_sub;
  logic [1:0]        req_sra;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [2*XLEN-1:0] rsp_data;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, req_sub, req_sra, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

  // Requester side
  modport master (
    output req_valid, req_a, req_b, req_op, req_sub, req_sra, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Grants at most one requester per cycle (round-robin on ties), steers the
// winner's fields to the ALU and latches the ALU result into that
// requester's one-entry response slot.
//
//   state | meaning
//   PREF0 | requester 0 wins a tie (reset value, or requester 1 granted last)
//   PREF1 | requester 1 wins a tie (requester 0 granted last)
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_sub,
  output logic            alu_sra,
  input  logic [XLEN-1:0] alu_out
);

  typedef enum logic {
    PREF0 = 1'b0,
    PREF1 = 1'b1
  } rr_state_e;

  rr_state_e state_q, state_d;

  logic [1:0]            elig;
  logic [1:0]            grant;
  logic [1:0]            slot_valid_q;
  logic [1:0][XLEN-1:0]  slot_data_q;

  // A requester may go only if its slot is free or being emptied right now.
  // rst_n gates it so nothing is offered while reset is held.
  assign elig = bus.req_valid & (~slot_valid_q | bus.rsp_ready) & {2{rst_n}};

  // Grant selection and tie-break pointer update; pointer moves only on a grant.
  always_comb begin
    grant   = 2'b00;
    state_d = state_q;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (state_q == PREF0) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      state_d = PREF1;
    end else if (grant[1]) begin
      state_d = PREF0;
    end
  end

  // Tie-break pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PREF0;
    end else begin
      state_q <= state_d;
    end
  end

  // Steer the granted requester's operation to the ALU; idle drives an ADD of 0+0.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 3'b000;
    alu_sub = 1'b0;
    alu_sra = 1'b0;
    if (grant[0]) begin
      alu_a   = bus.req_a[XLEN-1:0];
      alu_b   = bus.req_b[XLEN-1:0];
      alu_op  = bus.req_op[2:0];
      alu_sub = bus.req_sub[0];
      alu_sra = bus.req_sra[0];
    end else if (grant[1]) begin
      alu_a   = bus.req_a[2*XLEN-1:XLEN];
      alu_b   = bus.req_b[2*XLEN-1:XLEN];
      alu_op  = bus.req_op[5:3];
      alu_sub = bus.req_sub[1];
      alu_sra = bus.req_sra[1];
    end
  end

  // Response slots: a grant refills (even while draining), a drain alone empties,
  // otherwise the held result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 2'b00;
      slot_data_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          slot_valid_q[i] <= 1'b1;
          slot_data_q[i]  <= alu_out;
        end else if (bus.rsp_ready[i]) begin
          slot_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = slot_valid_q;
  assign bus.rsp_data  = slot_data_q;

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_grant_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (grant & ~bus.req_valid) == 2'b00);
  a_hold0 : assert property (@(posedge clk) disable iff (!rst_n)
    (slot_valid_q[0] && !bus.rsp_ready[0]) |=> $stable(slot_data_q[0]));
  a_hold1 : assert property (@(posedge clk) disable iff (!rst_n)
    (slot_valid_q[1] && !bus.rsp_ready[1]) |=> $stable(slot_data_q[1]));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reset checks, a directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_alu_arbiter;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] alu_a, alu_b, alu_out;
  logic [2:0]      alu_op;
  logic            alu_sub, alu_sra;

  int checks = 0;
  int fails  = 0;

  alu_arbiter_if #(.XLEN(XLEN)) bus ();

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_sub (alu_sub),
    .alu_sra (alu_sra),
    .alu_out (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32-style integer ALU, used both as the shared ALU and as the oracle.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic sub,
                                          input logic sra);
    logic [31:0] r;
    case (op)
      3'd0: r = sub ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'b0, ($signed(a) < $signed(b))};
      3'd3: r = {31'b0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: r = sra ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb alu_out = alu_ref(alu_a, alu_b, alu_op, alu_sub, alu_sra);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic sub, input logic sra);
    bus.req_a[i*XLEN +: XLEN] = a;
    bus.req_b[i*XLEN +: XLEN] = b;
    bus.req_op[i*3 +: 3]      = op;
    bus.req_sub[i]            = sub;
    bus.req_sra[i]            = sra;
  endtask

  function automatic logic [31:0] rsp_slice(input int i);
    return bus.rsp_data[i*XLEN +: XLEN];
  endfunction

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [31:0] a0, b0;
    logic [2:0]  op0;
    logic        sub0, sra0;
    logic [31:0] a1, b1;
    logic [2:0]  op1;
    logic        sub1, sra1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic [31:0] exp_d0, exp_d1;
  } vec_t;

  function automatic vec_t mkv(
    input logic [1:0] vld, input logic [1:0] rdy,
    input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
    input logic sub0, input logic sra0,
    input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
    input logic sub1, input logic sra1,
    input logic [1:0] exp_ready, input logic [1:0] exp_rv,
    input logic [31:0] exp_d0, input logic [31:0] exp_d1);
    vec_t v;
    v.vld = vld; v.rdy = rdy;
    v.a0 = a0; v.b0 = b0; v.op0 = op0; v.sub0 = sub0; v.sra0 = sra0;
    v.a1 = a1; v.b1 = b1; v.op1 = op1; v.sub1 = sub1; v.sra1 = sra1;
    v.exp_ready = exp_ready; v.exp_rv = exp_rv; v.exp_d0 = exp_d0; v.exp_d1 = exp_d1;
    return v;
  endfunction

  vec_t tbl[16];

  // Reference-model state for the randomized run.
  logic [1:0]  mv;
  logic [31:0] md[2];
  int          last_win;
  int          miss[2];

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  initial begin
    // Directed table, applied from reset with rsp_ready mostly high.
    tbl[0]  = mkv(2'b11, 2'b11, 32'd10, 32'd3, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd0, 3'd2, 1'b0, 1'b0, 2'b01, 2'b01, 32'd7, 32'd0);
    tbl[1]  = mkv(2'b11, 2'b11, 32'd10, 32'd3, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd0, 3'd2, 1'b0, 1'b0, 2'b10, 2'b10, 32'd0, 32'd1);
    tbl[2]  = mkv(2'b10, 2'b11, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'h80000000, 32'd4, 3'd5, 1'b0, 1'b1, 2'b10, 2'b10, 32'd0, 32'hF8000000);
    tbl[3]  = mkv(2'b10, 2'b11, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'h80000000, 32'd4, 3'd5, 1'b0, 1'b0, 2'b10, 2'b10, 32'd0, 32'h08000000);
    tbl[4]  = mkv(2'b01, 2'b11, 32'd5, 32'd3, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b01, 2'b01, 32'd8, 32'd0);
    tbl[5]  = mkv(2'b00, 2'b11, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    tbl[6]  = mkv(2'b11, 2'b11, 32'hFF00FF00, 32'h0F0F0F0F, 3'd7, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 3'd4, 1'b0, 1'b0, 2'b10, 2'b10, 32'd0, 32'h0000FF00);
    tbl[7]  = mkv(2'b11, 2'b11, 32'hFF00FF00, 32'h0F0F0F0F, 3'd7, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 3'd4, 1'b0, 1'b0, 2'b01, 2'b01, 32'h0F000F00, 32'd0);
    tbl[8]  = mkv(2'b01, 2'b11, 32'd1, 32'd31, 3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b01, 2'b01, 32'h80000000, 32'd0);
    tbl[9]  = mkv(2'b10, 2'b11, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 3'd3, 1'b0, 1'b0, 2'b10, 2'b10, 32'd0, 32'd1);
    tbl[10] = mkv(2'b01, 2'b11, 32'h000000F0, 32'h00000F00, 3'd6, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b01, 2'b01, 32'h00000FF0, 32'd0);
    tbl[11] = mkv(2'b01, 2'b11, 32'd3, 32'd5, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b01, 2'b01, 32'hFFFFFFFE, 32'd0);
    tbl[12] = mkv(2'b11, 2'b00, 32'd3, 32'd5, 3'd0, 1'b1, 1'b0, 32'd7, 32'd9, 3'd0, 1'b0, 1'b0, 2'b10, 2'b11, 32'hFFFFFFFE, 32'd16);
    tbl[13] = mkv(2'b11, 2'b00, 32'd3, 32'd5, 3'd0, 1'b1, 1'b0, 32'd7, 32'd9, 3'd0, 1'b0, 1'b0, 2'b00, 2'b11, 32'hFFFFFFFE, 32'd16);
    tbl[14] = mkv(2'b11, 2'b01, 32'h11, 32'h22, 3'd0, 1'b0, 1'b0, 32'd7, 32'd9, 3'd0, 1'b0, 1'b0, 2'b01, 2'b11, 32'h33, 32'd16);
    tbl[15] = mkv(2'b00, 2'b11, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);

    // Reset state, with requests already pending.
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    drive_req(0, 32'h1234, 32'h5678, 3'd4, 1'b1, 1'b1);
    drive_req(1, 32'hABCD, 32'h0001, 3'd6, 1'b1, 1'b1);
    #2;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctl", {alu_op, alu_sub, alu_sra}, 5'd0);
    @(posedge clk); #1;
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_req_ready_after_edge", bus.req_ready, 2'b00);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    // Directed vectors.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.req_valid = tbl[k].vld;
      bus.rsp_ready = tbl[k].rdy;
      drive_req(0, tbl[k].a0, tbl[k].b0, tbl[k].op0, tbl[k].sub0, tbl[k].sra0);
      drive_req(1, tbl[k].a1, tbl[k].b1, tbl[k].op1, tbl[k].sub1, tbl[k].sra1);
      #1;
      chk($sformatf("tbl%0d_req_ready", k), bus.req_ready, tbl[k].exp_ready);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rsp_valid", k), bus.rsp_valid, tbl[k].exp_rv);
      if (tbl[k].exp_rv[0]) chk($sformatf("tbl%0d_rsp_data0", k), rsp_slice(0), tbl[k].exp_d0);
      if (tbl[k].exp_rv[1]) chk($sformatf("tbl%0d_rsp_data1", k), rsp_slice(1), tbl[k].exp_d1);
    end

    // Stalled slot 0 blocks only requester 0; its result stays put.
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b10;
    drive_req(0, 32'd100, 32'd1, 3'd0, 1'b0, 1'b0);
    #1;
    chk("stall_first_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    chk("stall_first_data", rsp_slice(0), 32'd101);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b10;
      drive_req(0, 32'd200 + 32'(k), 32'd0, 3'd0, 1'b0, 1'b0);
      drive_req(1, 32'(k), 32'd1000, 3'd0, 1'b0, 1'b0);
      #1;
      chk("stall_req_ready", bus.req_ready, 2'b10);
      @(posedge clk); #1;
      chk("stall_rsp_valid", bus.rsp_valid, 2'b11);
      chk("stall_hold_data0", rsp_slice(0), 32'd101);
      chk("stall_data1", rsp_slice(1), 32'd1000 + 32'(k));
    end
    @(negedge clk);
    bus.rsp_ready = 2'b11;
    drive_req(0, 32'd300, 32'd0, 3'd0, 1'b0, 1'b0);
    #1;
    chk("unstall_same_cycle_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    chk("unstall_data0", rsp_slice(0), 32'd300);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    chk("idle_drained", bus.rsp_valid, 2'b00);

    // Fill both slots, then reset mid-cycle.
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    #1;
    chk("fill_grant_a", bus.req_ready, 2'b10);
    @(negedge clk);
    #1;
    chk("fill_grant_b", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    chk("fill_rsp_valid", bus.rsp_valid, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("async_rst_rsp_data", bus.rsp_data, 64'd0);
    chk("async_rst_req_ready", bus.req_ready, 2'b00);
    chk("async_rst_alu_a", alu_a, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_rsp_valid", bus.rsp_valid, 2'b00);

    // Release, then sustained contention for 8 cycles with all slots draining.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) rst_n = 1'b1;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      drive_req(0, 32'h100 + 32'(c), 32'd0, 3'd0, 1'b0, 1'b0);
      drive_req(1, 32'h200 + 32'(c), 32'd0, 3'd0, 1'b0, 1'b0);
      #1;
      chk($sformatf("rr_grant_c%0d", c), bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      if (bus.rsp_valid[0]) q0.push_back(rsp_slice(0));
      if (bus.rsp_valid[1]) q1.push_back(rsp_slice(1));
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    if (bus.rsp_valid[0]) q0.push_back(rsp_slice(0));
    if (bus.rsp_valid[1]) q1.push_back(rsp_slice(1));
    chk("rr_count0", q0.size(), 4);
    chk("rr_count1", q1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < q0.size()) chk($sformatf("rr_order0_%0d", k), q0[k], 32'h100 + 32'(2*k));
      if (k < q1.size()) chk($sformatf("rr_order1_%0d", k), q1[k], 32'h201 + 32'(2*k));
    end

    // Randomized run against the reference model, starting from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    mv = 2'b00;
    md[0] = '0;
    md[1] = '0;
    last_win = 1;
    miss[0] = 0;
    miss[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0]  vld, rdy, el, exp_ready;
      logic [31:0] ra[2], rb[2];
      logic [2:0]  rop[2];
      logic        rsub[2], rsra[2];
      int          winner;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vld[i]  = ($urandom_range(0, 3) != 0);
        rdy[i]  = ($urandom_range(0, 9) < 7);
        ra[i]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        rb[i]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        rop[i]  = 3'($urandom_range(0, 7));
        rsub[i] = 1'($urandom_range(0, 1));
        rsra[i] = 1'($urandom_range(0, 1));
        drive_req(i, ra[i], rb[i], rop[i], rsub[i], rsra[i]);
      end
      bus.req_valid = vld;
      bus.rsp_ready = rdy;
      for (int i = 0; i < 2; i++) el[i] = vld[i] && (!mv[i] || rdy[i]);
      winner = -1;
      if (el[0] && el[1]) winner = (last_win == 0) ? 1 : 0;
      else if (el[0])     winner = 0;
      else if (el[1])     winner = 1;
      exp_ready = (winner < 0) ? 2'b00 : (2'b01 << winner);
      #1;
      chk("rnd_req_ready", bus.req_ready, exp_ready);
      chk("rnd_alu_a", alu_a, (winner < 0) ? 32'd0 : ra[winner]);
      chk("rnd_alu_op", alu_op, (winner < 0) ? 3'd0 : rop[winner]);
      for (int i = 0; i < 2; i++) begin
        if (el[i] && winner != i) begin
          miss[i]++;
          chk("rnd_fair_wait", (miss[i] <= 1), 1'b1);
        end else begin
          miss[i] = 0;
        end
        if (winner == i) begin
          mv[i] = 1'b1;
          md[i] = alu_ref(ra[i], rb[i], rop[i], rsub[i], rsra[i]);
        end else if (rdy[i]) begin
          mv[i] = 1'b0;
        end
      end
      if (winner >= 0) last_win = winner;
      @(posedge clk); #1;
      chk("rnd_rsp_valid", bus.rsp_valid, mv);
      for (int i = 0; i < 2; i++)
        if (mv[i]) chk($sformatf("rnd_rsp_data%0d", i), rsp_slice(i), md[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, ALU operand/result width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  2  bit i: requester i presents an operation.
REQ-005 req_ready  out  2  bit i: operation i accepted this cycle.
REQ-006 req_a, req_b  in  2*XLEN each  operands; slice [i*XLEN +: XLEN] belongs to requester i.
REQ-007 req_op  in  6  3-bit funct3 per requester, slice [i*3 +: 3].
REQ-008 req_sub, req_sra  in  2 each  per-requester sub and sra modifiers.
REQ-009 rsp_valid  out  2  bit i: rsp_data slice i holds a result for requester i.
REQ-010 rsp_ready  in  2  bit i: requester i consumes its result.
REQ-011 rsp_data  out  2*XLEN  per-requester result, slice [i*XLEN +: XLEN].
REQ-012 alu_a, alu_b  out  XLEN each  operands to the shared ALU instance.
REQ-013 alu_op  out  3; alu_sub, alu_sra  out  1 each  controls to the shared ALU.
REQ-014 alu_out  in  XLEN  combinational ALU result.

Function
REQ-015 One shared combinational ALU; at most one requester granted per cycle.
REQ-016 Requester i eligible when req_valid[i]=1 and its response slot is empty or is being drained this cycle (rsp_valid[i]&&rsp_ready[i]).
REQ-017 Only one eligible: it is granted.
REQ-018 Both eligible: grant the requester not granted most recently (round-robin); after reset requester 0 wins first tie.
REQ-019 Round-robin pointer updates only on a grant; a cycle with no grant leaves it unchanged.
REQ-020 req_ready = grant vector, combinational from req_valid, rsp state and pointer; at most one bit set; req_ready[i]=0 whenever req_valid[i]=0.
REQ-021 alu_a/alu_b/alu_op/alu_sub/alu_sra driven from the granted requester's fields; no grant: all driven 0 (op=ADD, add of 0+0).
REQ-022 On grant to i: alu_out captured into slot i at the clock edge; rsp_valid[i]=1 from the next cycle (latency exactly 1 cycle).
REQ-023 Slot i holds rsp_data stable while rsp_valid[i]=1 and rsp_ready[i]=0.
REQ-024 Drain without new grant: rsp_valid[i] clears next cycle; drain with same-cycle grant: rsp_valid[i] stays 1 with new data (back-to-back throughput 1/cycle per requester).
REQ-025 Full slot (rsp_valid[i]=1, rsp_ready[i]=0) blocks requester i only; the other requester is still granted if eligible.
REQ-026 Sustained contention with both slots draining: grants alternate 0,1,0,1; no requester waits more than one cycle behind the other.
REQ-027 rsp_ready[i] while rsp_valid[i]=0 is ignored.
REQ-028 Arbiter does no arithmetic; results are bit-exact alu_out, no width change.

Reset
REQ-029 rst_n low asynchronously clears rsp_valid to 2'b00, rsp_data to 0, pointer to "requester 0 preferred".
REQ-030 While rst_n low req_ready=2'b00 and all alu_* outputs 0.
REQ-031 Results in flight when reset asserts are discarded; no grant in the first cycle counts until rst_n is sampled high at a rising edge.

Verification
REQ-032 Req0 ADD a=5 b=3 alone, rsp_ready=1 -> req_ready=2'b01 same cycle; next cycle rsp_valid=2'b01, rsp_data[0]=8.
REQ-033 After reset both request (req0 SUB 10-3, req1 SLT a=0xFFFFFFFF b=0), both rsp_ready=1 -> cycle 0 grant 01, cycle 1 grant 10; rsp_data[0]=7, rsp_data[1]=1.
REQ-034 rsp_ready[0]=0 after one req0 result, req0 and req1 keep requesting -> req_ready[0]=0 every cycle, req1 granted each cycle, rsp_data[0] stable; raise rsp_ready[0] -> req0 granted the same cycle.
REQ-035 Req1 op=101 sra=1 a=0x80000000 b=4 -> rsp_data[1]=0xF8000000; sra=0 -> 0x08000000.
REQ-036 Both requesting continuously 8 cycles, all ready -> grants 01,10,01,10,...; 4 results each, in order.
REQ-037 Assert rst_n low mid-stream with rsp_valid=2'b11 -> rsp_valid=2'b00 immediately (before next edge); first grant after release goes to req0 on a tie.
